// File: rtl/alu_pkg.sv
// Shared opcode constants, beat record and occupancy states for the
// ALU result stage.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] data;
    logic                 overflow;
    logic                 zero;
    logic                 negative;
    logic [2:0]           control;
  } alu_beat_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Only add/subtract can meaningfully overflow; other opcodes drop the flag.
  function automatic logic mask_overflow(input logic ovf, input logic [2:0] ctrl);
    return ovf && (ctrl == ALU_ADD || ctrl == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Valid/ready bundle between the ALU, the result stage and its consumer.
interface alu_result_stage_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_out;
  logic             in_overflow;
  logic             in_zero;
  logic             in_negative;
  logic [2:0]       in_control;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_overflow;
  logic             out_zero;
  logic             out_negative;
  logic [2:0]       out_control;

  modport master (
    output in_valid, in_out, in_overflow, in_zero, in_negative, in_control,
    input  in_ready,
    input  out_valid, out_data, out_overflow, out_zero, out_negative, out_control,
    output out_ready
  );

  modport slave (
    input  in_valid, in_out, in_overflow, in_zero, in_negative, in_control,
    output in_ready,
    output out_valid, out_data, out_overflow, out_zero, out_negative, out_control,
    input  out_ready
  );

endinterface

// File: rtl/alu_skid_buf.sv
// Two-entry skid buffer (main + skid) with an EMPTY/ONE/FULL occupancy FSM;
// in_ready comes straight from a flop so out_ready never reaches it.
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter type beat_t = alu_beat_t
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  in_valid,
  output logic  in_ready,
  input  beat_t in_beat,
  output logic  out_valid,
  input  logic  out_ready,
  output beat_t out_beat
);

  state_t state, next_state;
  beat_t  main_q, skid_q;
  logic   in_ready_q;
  logic   accept, consume;
  logic   load_main, load_skid, main_from_skid;

  assign accept    = in_valid && in_ready_q;
  assign consume   = out_valid && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state != ST_EMPTY);
  assign out_beat  = main_q;

  always_comb begin
    next_state     = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          next_state = ST_ONE;
          load_main  = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !consume) begin
          next_state = ST_FULL;
          load_skid  = 1'b1;
        end else if (!accept && consume) begin
          next_state = ST_EMPTY;
        end else if (accept && consume) begin
          load_main = 1'b1;
        end
      end
      ST_FULL: begin
        if (consume) begin
          next_state     = ST_ONE;
          main_from_skid = 1'b1;
        end
      end
      default: next_state = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state      <= next_state;
      in_ready_q <= (next_state != ST_FULL);
      if (load_main)
        main_q <= in_beat;
      else if (main_from_skid)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= in_beat;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: overflow masking, skid-buffered handshake,
// sticky overflow status and a wrapping accepted-operation counter.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  alu_result_stage_if.slave    bus,
  input  logic                 clear_sticky,
  output logic                 sticky_ovf,
  output logic [CNT_W-1:0]     op_count
);

  alu_beat_t        in_beat, out_beat;
  logic [WIDTH-1:0] in_data;
  logic             accept;

  assign in_data = bus.in_out;

  always_comb begin
    in_beat.data     = in_data;
    in_beat.overflow = mask_overflow(bus.in_overflow, bus.in_control);
    in_beat.zero     = bus.in_zero;
    in_beat.negative = bus.in_negative;
    in_beat.control  = bus.in_control;
  end

  alu_skid_buf #(.beat_t(alu_beat_t)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_beat   (in_beat),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_beat  (out_beat)
  );

  assign accept           = bus.in_valid && bus.in_ready;
  assign bus.out_data     = out_beat.data;
  assign bus.out_overflow = out_beat.overflow;
  assign bus.out_zero     = out_beat.zero;
  assign bus.out_negative = out_beat.negative;
  assign bus.out_control  = out_beat.control;

  // A new overflow in the same cycle as a clear must not be lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sticky_ovf <= 1'b0;
      op_count   <= '0;
    end else begin
      if (accept && in_beat.overflow)
        sticky_ovf <= 1'b1;
      else if (clear_sticky)
        sticky_ovf <= 1'b0;
      if (accept)
        op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;
  import alu_pkg::*;

  logic        clock;
  logic        reset;
  logic        clear_sticky;
  logic        sticky_ovf;
  logic [15:0] op_count;
  int          checks;
  int          failures;

  alu_result_stage_if #(.WIDTH(32)) bus ();

  alu_result_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus.slave),
    .clear_sticky (clear_sticky),
    .sticky_ovf   (sticky_ovf),
    .op_count     (op_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic ovf,
                               input logic zero, input logic neg, input logic [2:0] ctrl);
    bus.in_valid    = valid;
    bus.in_out      = data;
    bus.in_overflow = ovf;
    bus.in_zero     = zero;
    bus.in_negative = neg;
    bus.in_control  = ctrl;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b0;
    clear_sticky = 1'b0;
    bus.out_ready = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    tick();
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_in_ready", bus.in_ready, 1'b1);
    checkOutput("rst_out_data", bus.out_data, 32'h0);
    checkOutput("rst_flags", {bus.out_overflow, bus.out_zero, bus.out_negative}, 3'b000);
    checkOutput("rst_control", bus.out_control, 3'd0);
    checkOutput("rst_sticky", sticky_ovf, 1'b0);
    checkOutput("rst_count", op_count, 16'd0);
    reset = 1'b1;

    // ADD with overflow: flag passes through and sets sticky
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1, ALU_ADD);
    tick();
    checkOutput("add_valid", bus.out_valid, 1'b1);
    checkOutput("add_data", bus.out_data, 32'h8000_0000);
    checkOutput("add_ovf", bus.out_overflow, 1'b1);
    checkOutput("add_neg", bus.out_negative, 1'b1);
    checkOutput("add_sticky", sticky_ovf, 1'b1);
    checkOutput("add_count", op_count, 16'd1);

    // AND with overflow raised: flag masked, sticky unchanged
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, ALU_AND);
    tick();
    checkOutput("and_ovf", bus.out_overflow, 1'b0);
    checkOutput("and_zero", bus.out_zero, 1'b1);
    checkOutput("and_control", bus.out_control, ALU_AND);
    checkOutput("and_sticky", sticky_ovf, 1'b1);
    checkOutput("and_count", op_count, 16'd2);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    checkOutput("drain_valid", bus.out_valid, 1'b0);

    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    checkOutput("clear_sticky", sticky_ovf, 1'b0);

    // Back-pressure: beats 1,2 fill the buffer, beat 3 waits upstream
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 32'd1, 1'b0, 1'b0, 1'b0, ALU_OR);
    tick();
    checkOutput("bp1_in_ready", bus.in_ready, 1'b1);
    applyStimulus(1'b1, 32'd2, 1'b0, 1'b0, 1'b0, ALU_OR);
    tick();
    checkOutput("bp2_in_ready", bus.in_ready, 1'b0);
    checkOutput("bp2_data", bus.out_data, 32'd1);
    applyStimulus(1'b1, 32'd3, 1'b0, 1'b0, 1'b0, ALU_OR);
    tick();
    checkOutput("bp3_hold_data", bus.out_data, 32'd1);
    checkOutput("bp3_in_ready", bus.in_ready, 1'b0);
    checkOutput("bp3_count", op_count, 16'd4);
    bus.out_ready = 1'b1;
    tick();
    checkOutput("rel_data2", bus.out_data, 32'd2);
    checkOutput("rel_valid2", bus.out_valid, 1'b1);
    checkOutput("rel_in_ready", bus.in_ready, 1'b1);
    tick();
    checkOutput("rel_data3", bus.out_data, 32'd3);
    checkOutput("rel_valid3", bus.out_valid, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    checkOutput("rel_empty", bus.out_valid, 1'b0);
    checkOutput("rel_count", op_count, 16'd5);

    // Set and clear in the same cycle: set wins
    clear_sticky = 1'b1;
    applyStimulus(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, ALU_SUB);
    tick();
    clear_sticky = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    checkOutput("setclr_sticky", sticky_ovf, 1'b1);
    checkOutput("setclr_ovf", bus.out_overflow, 1'b1);
    tick();

    // Stream to reach 16'hFFFF, then one more accept wraps to 0
    for (int i = 0; i < 65535 - 6; i++) begin
      applyStimulus(1'b1, i, 1'b0, 1'b0, 1'b0, ALU_XOR);
      tick();
    end
    checkOutput("stream_data", bus.out_data, 32'd65528);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    checkOutput("count_max", op_count, 16'hFFFF);
    applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, ALU_NOR);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    checkOutput("count_wrap", op_count, 16'd0);
    tick();

    // Reset while FULL discards both entries immediately
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, ALU_ADD);
    tick();
    applyStimulus(1'b1, 32'hB, 1'b0, 1'b0, 1'b0, ALU_ADD);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    checkOutput("full_in_ready", bus.in_ready, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst_out_valid", bus.out_valid, 1'b0);
    checkOutput("arst_in_ready", bus.in_ready, 1'b1);
    checkOutput("arst_count", op_count, 16'd0);
    tick();
    reset = 1'b1;
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, ALU_AND);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    checkOutput("post_data", bus.out_data, 32'hC);
    checkOutput("post_count", op_count, 16'd1);
    tick();
    checkOutput("post_in_ready", bus.in_ready, 1'b1);
    checkOutput("post_hold", bus.out_data, 32'hC);
    bus.out_ready = 1'b1;
    tick();
    checkOutput("post_alone", bus.out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
